// File: rtl/inunit_blk_stats_pkg.sv
// ----------------------------------------------------------------------------
// inunit_pkg
//   Shared constants and types for the luminance block-statistics unit.
//   - BT.601-style integer Y coefficients (sum to 256, so the >> 8 keeps
//     white at full scale).
//   - Drain FSM state type.
//   - Width helpers used to size indices, pixel/line counters and sums.
// ----------------------------------------------------------------------------
package inunit_pkg;

  localparam int unsigned Y_COEF_R = 77;
  localparam int unsigned Y_COEF_G = 150;
  localparam int unsigned Y_COEF_B = 29;
  localparam int unsigned Y_SHIFT  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } blk_state_e;

  // Zone index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width that can also hold the terminal value blocks*blk,
  // so the counter saturates there instead of wrapping back into range.
  function automatic int unsigned cnt_w(input int unsigned blocks,
                                        input int unsigned blk);
    return $clog2(blocks * blk) + 1;
  endfunction

  // Sum width: every pixel of a zone at full scale still fits.
  function automatic int unsigned sum_w(input int unsigned y_w,
                                        input int unsigned blk_w,
                                        input int unsigned blk_h);
    return y_w + $clog2(blk_w * blk_h);
  endfunction

endpackage

// File: rtl/inunit_blk_stats_rgb2y_pipe.sv
// ----------------------------------------------------------------------------
// rgb2y_pipe
//   Three-stage RGB -> Y conversion with the data enable delayed in lockstep.
//     stage 1: per-channel coefficient products
//     stage 2: sum of products
//     stage 3: >> Y_SHIFT
// Ports:
//   i_clk    pixel clock (rising edge)
//   i_rst_n  asynchronous active-low reset
//   i_de     data enable aligned with i_rgb
//   i_rgb    {R, G, B}, each Y_W bits, R in the top bits
//   o_de     i_de delayed by three cycles
//   o_y      luminance aligned with o_de
// ----------------------------------------------------------------------------
module rgb2y_pipe
  import inunit_pkg::*;
#(
  parameter int unsigned Y_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_de,
  input  logic [3*Y_W-1:0] i_rgb,
  output logic             o_de,
  output logic [Y_W-1:0]   o_y
);

  // Coefficients sum to 256, so Y_W + 8 bits already holds the full sum;
  // two spare bits give the 18-bit intermediate at Y_W = 8.
  localparam int unsigned P_W = Y_W + 10;

  logic [Y_W-1:0] w_r;
  logic [Y_W-1:0] w_g;
  logic [Y_W-1:0] w_b;
  logic [P_W-1:0] r_pr;
  logic [P_W-1:0] r_pg;
  logic [P_W-1:0] r_pb;
  logic [P_W-1:0] r_sum;
  logic [Y_W-1:0] r_y;
  logic [2:0]     r_de_sr;

  assign w_r = i_rgb[3*Y_W-1:2*Y_W];
  assign w_g = i_rgb[2*Y_W-1:Y_W];
  assign w_b = i_rgb[Y_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pr    <= '0;
      r_pg    <= '0;
      r_pb    <= '0;
      r_sum   <= '0;
      r_y     <= '0;
      r_de_sr <= '0;
    end else begin
      r_pr    <= P_W'(w_r) * P_W'(Y_COEF_R);
      r_pg    <= P_W'(w_g) * P_W'(Y_COEF_G);
      r_pb    <= P_W'(w_b) * P_W'(Y_COEF_B);
      r_sum   <= r_pr + r_pg + r_pb;
      r_y     <= Y_W'(r_sum >> Y_SHIFT);
      r_de_sr <= {r_de_sr[1:0], i_de};
    end
  end

  assign o_de = r_de_sr[2];
  assign o_y  = r_y;

endmodule

// File: rtl/inunit_blk_stats.sv
// ----------------------------------------------------------------------------
// inunit_blk_stats
//   Converts the RGB pixel stream to Y, splits the active frame into
//   H_BLOCKS x V_BLOCKS zones and streams per-zone max Y (and optionally the
//   mean) to the dimming algorithm over a valid/ready handshake, one zone
//   row at a time.
//
//   Optional feature macro: INUNIT_BLK_AVG_EN
//     defined   -> per-zone sum accumulators and the oBlk_Avg port exist
//     undefined -> max-only build
//
// Ports:
//   iODCK        pixel clock (rising edge)
//   iRST_n       asynchronous active-low reset
//   iDE          data enable, high during active pixels
//   iVSYNC       frame sync, active high, synchronous frame clear
//   iQE          {R, G, B} pixel
//   oBlk_Valid   zone result available
//   iBlk_Ready   consumer accepts when high together with oBlk_Valid
//   oBlk_HIdx    zone column
//   oBlk_VIdx    zone row
//   oBlk_Max     maximum Y of the zone
//   oBlk_Avg     mean Y of the zone (INUNIT_BLK_AVG_EN only)
//   oFrame_Done  one-cycle pulse after the last zone of the frame is accepted
//   oOvf         sticky: a completed zone row was dropped while draining
//
// Drain FSM:
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | accumulating; waiting for a zone row to complete
//   DRAIN | presenting buffered zone row, one column per accept
// ----------------------------------------------------------------------------
module inunit_blk_stats
  import inunit_pkg::*;
#(
  parameter int unsigned H_BLOCKS = 8,
  parameter int unsigned V_BLOCKS = 8,
  parameter int unsigned BLK_W    = 128,
  parameter int unsigned BLK_H    = 64,
  parameter int unsigned Y_W      = 8
) (
  input  logic                        iODCK,
  input  logic                        iRST_n,
  input  logic                        iDE,
  input  logic                        iVSYNC,
  input  logic [3*Y_W-1:0]            iQE,
  output logic                        oBlk_Valid,
  input  logic                        iBlk_Ready,
  output logic [idx_w(H_BLOCKS)-1:0]  oBlk_HIdx,
  output logic [idx_w(V_BLOCKS)-1:0]  oBlk_VIdx,
  output logic [Y_W-1:0]              oBlk_Max,
`ifdef INUNIT_BLK_AVG_EN
  output logic [Y_W-1:0]              oBlk_Avg,
`endif
  output logic                        oFrame_Done,
  output logic                        oOvf
);

  localparam int unsigned IDX_H  = idx_w(H_BLOCKS);
  localparam int unsigned IDX_V  = idx_w(V_BLOCKS);
  localparam int unsigned HC_LIM = H_BLOCKS * BLK_W;
  localparam int unsigned VC_LIM = V_BLOCKS * BLK_H;
  localparam int unsigned HC_W   = cnt_w(H_BLOCKS, BLK_W);
  localparam int unsigned VC_W   = cnt_w(V_BLOCKS, BLK_H);
  localparam int unsigned LOG_BW = $clog2(BLK_W);
  localparam int unsigned LOG_BH = $clog2(BLK_H);

  // --------------------------------------------------------------------------
  // Y conversion
  // --------------------------------------------------------------------------
  logic [Y_W-1:0] w_y;
  logic           w_de;

  rgb2y_pipe #(
    .Y_W (Y_W)
  ) u_rgb2y (
    .i_clk   (iODCK),
    .i_rst_n (iRST_n),
    .i_de    (iDE),
    .i_rgb   (iQE),
    .o_de    (w_de),
    .o_y     (w_y)
  );

  // --------------------------------------------------------------------------
  // Pixel / line position
  // --------------------------------------------------------------------------
  logic            r_de_q;
  logic [HC_W-1:0] r_hc;
  logic [VC_W-1:0] r_vc;
  logic            w_de_fall;
  logic            w_hc_in;
  logic            w_vc_in;
  logic            w_px;
  logic [IDX_H-1:0] w_col_px;
  logic            w_row_done;
  logic            w_acc_clr;

  assign w_de_fall  = r_de_q & ~w_de;
  assign w_hc_in    = (r_hc < HC_W'(HC_LIM));
  assign w_vc_in    = (r_vc < VC_W'(VC_LIM));
  assign w_px       = w_de & w_hc_in & w_vc_in;
  assign w_col_px   = IDX_H'(r_hc >> LOG_BW);
  // Last line of a zone row ends; BLK_H is a power of two so a mask is a mod.
  assign w_row_done = w_de_fall & w_vc_in &
                      ((r_vc & VC_W'(BLK_H - 1)) == VC_W'(BLK_H - 1));
  assign w_acc_clr  = iVSYNC | w_row_done;

  always_ff @(posedge iODCK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_de_q <= 1'b0;
      r_hc   <= '0;
      r_vc   <= '0;
    end else begin
      r_de_q <= w_de;
      if (iVSYNC || !w_de) begin
        r_hc <= '0;
      end else if (w_hc_in) begin
        r_hc <= r_hc + 1'b1;
      end
      if (iVSYNC) begin
        r_vc <= '0;
      end else if (w_de_fall && w_vc_in) begin
        r_vc <= r_vc + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM
  // --------------------------------------------------------------------------
  blk_state_e       r_state;
  blk_state_e       w_state_nxt;
  logic [IDX_H-1:0] r_col;
  logic [IDX_H-1:0] w_col_nxt;
  logic [IDX_V-1:0] r_row;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ovf;
  logic             w_ovf_set;
  logic             w_snap;

  always_ff @(posedge iODCK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_done  <= w_done_nxt;
      if (iVSYNC) begin
        r_row <= '0;
      end else if (w_snap) begin
        r_row <= IDX_V'(r_vc >> LOG_BH);
      end
      if (iVSYNC) begin
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_done_nxt  = 1'b0;
    w_ovf_set   = 1'b0;
    w_snap      = 1'b0;
    if (iVSYNC) begin
      w_state_nxt = IDLE;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_row_done) begin
            w_snap      = 1'b1;
            w_state_nxt = DRAIN;
            w_col_nxt   = '0;
          end
        end
        DRAIN: begin
          // The buffer is busy; a row finishing now is lost.
          if (w_row_done) begin
            w_ovf_set = 1'b1;
          end
          if (iBlk_Ready) begin
            if (r_col == IDX_H'(H_BLOCKS - 1)) begin
              w_state_nxt = IDLE;
              w_col_nxt   = '0;
              w_done_nxt  = (r_row == IDX_V'(V_BLOCKS - 1));
            end else begin
              w_col_nxt = r_col + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_col_nxt   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-column max accumulators and drain buffer
  // --------------------------------------------------------------------------
  logic [Y_W-1:0] r_max     [H_BLOCKS];
  logic [Y_W-1:0] r_buf_max [H_BLOCKS];

  always_ff @(posedge iODCK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int c = 0; c < int'(H_BLOCKS); c++) begin
        r_max[c]     <= '0;
        r_buf_max[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(H_BLOCKS); c++) begin
        if (w_acc_clr) begin
          r_max[c] <= '0;
        end else if (w_px && (w_col_px == IDX_H'(c)) && (w_y > r_max[c])) begin
          r_max[c] <= w_y;
        end
        if (w_snap) begin
          r_buf_max[c] <= r_max[c];
        end
      end
    end
  end

`ifdef INUNIT_BLK_AVG_EN
  localparam int unsigned SUM_W  = sum_w(Y_W, BLK_W, BLK_H);
  localparam int unsigned LOG_BA = $clog2(BLK_W * BLK_H);

  logic [SUM_W-1:0] r_sum     [H_BLOCKS];
  logic [Y_W-1:0]   r_buf_avg [H_BLOCKS];

  always_ff @(posedge iODCK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int c = 0; c < int'(H_BLOCKS); c++) begin
        r_sum[c]     <= '0;
        r_buf_avg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(H_BLOCKS); c++) begin
        if (w_acc_clr) begin
          r_sum[c] <= '0;
        end else if (w_px && (w_col_px == IDX_H'(c))) begin
          r_sum[c] <= r_sum[c] + SUM_W'(w_y);
        end
        // Truncating divide by the zone pixel count.
        if (w_snap) begin
          r_buf_avg[c] <= Y_W'(r_sum[c] >> LOG_BA);
        end
      end
    end
  end

  assign oBlk_Avg = oBlk_Valid ? r_buf_avg[r_col] : '0;
`else
  // Max-only build: no sum accumulators or average snapshot exist.
`endif

  // --------------------------------------------------------------------------
  // Outputs: zone fields are forced to zero outside DRAIN.
  // --------------------------------------------------------------------------
  assign oBlk_Valid  = (r_state == DRAIN);
  assign oBlk_HIdx   = oBlk_Valid ? r_col : '0;
  assign oBlk_VIdx   = oBlk_Valid ? r_row : '0;
  assign oBlk_Max    = oBlk_Valid ? r_buf_max[r_col] : '0;
  assign oFrame_Done = r_done;
  assign oOvf        = r_ovf;

endmodule

// File: tb/tb_inunit_blk_stats.sv
module tb_inunit_blk_stats;

  localparam int H  = 2;
  localparam int V  = 2;
  localparam int BW = 4;
  localparam int BH = 2;

  logic        iODCK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iDE = 1'b0;
  logic        iVSYNC = 1'b0;
  logic        iBlk_Ready = 1'b0;
  logic [23:0] iQE = '0;
  logic        oBlk_Valid;
  logic [0:0]  oBlk_HIdx;
  logic [0:0]  oBlk_VIdx;
  logic [7:0]  oBlk_Max;
  logic [7:0]  oBlk_Avg;
  logic        oFrame_Done;
  logic        oOvf;

  inunit_blk_stats #(
    .H_BLOCKS (H),
    .V_BLOCKS (V),
    .BLK_W    (BW),
    .BLK_H    (BH),
    .Y_W      (8)
  ) dut (
    .iODCK       (iODCK),
    .iRST_n      (iRST_n),
    .iDE         (iDE),
    .iVSYNC      (iVSYNC),
    .iQE         (iQE),
    .oBlk_Valid  (oBlk_Valid),
    .iBlk_Ready  (iBlk_Ready),
    .oBlk_HIdx   (oBlk_HIdx),
    .oBlk_VIdx   (oBlk_VIdx),
    .oBlk_Max    (oBlk_Max),
`ifdef INUNIT_BLK_AVG_EN
    .oBlk_Avg    (oBlk_Avg),
`endif
    .oFrame_Done (oFrame_Done),
    .oOvf        (oOvf)
  );

`ifndef INUNIT_BLK_AVG_EN
  assign oBlk_Avg = '0;
`endif

  always #5 iODCK = ~iODCK;

  typedef struct {
    int h;
    int v;
    int mx;
    int av;
    int cyc;
  } res_t;

  res_t        got_q[$];
  res_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          rdy_mode = 0;
  logic [23:0] pix [6][12];

  always @(posedge iODCK) cyc <= cyc + 1;

  // Accepts are sampled mid-cycle; the accepting edge is the next posedge.
  always @(negedge iODCK) begin
    res_t r;
    if (oBlk_Valid && iBlk_Ready) begin
      r.h   = int'(oBlk_HIdx);
      r.v   = int'(oBlk_VIdx);
      r.mx  = int'(oBlk_Max);
      r.av  = int'(oBlk_Avg);
      r.cyc = cyc + 1;
      got_q.push_back(r);
    end
    if (oFrame_Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    case (rdy_mode)
      0:       iBlk_Ready = 1'b0;
      1:       iBlk_Ready = 1'b1;
      default: iBlk_Ready = ($urandom_range(3) != 0);
    endcase
    @(posedge iODCK);
    #1;
  endtask

  function automatic int y_of(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  function automatic logic [23:0] gray(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b, b, b};
  endfunction

  task automatic fill_random();
    for (int l = 0; l < 6; l++)
      for (int x = 0; x < 12; x++)
        pix[l][x] = 24'($urandom);
  endtask

  // Reference: each zone's max and truncated mean over in-range pixels;
  // only zone rows whose every line was sent produce results.
  task automatic build_exp(input int nl, input int np);
    int   mx [V][H];
    int   sm [V][H];
    int   y;
    res_t r;
    exp_q.delete();
    for (int zy = 0; zy < V; zy++)
      for (int zx = 0; zx < H; zx++) begin
        mx[zy][zx] = 0;
        sm[zy][zx] = 0;
      end
    for (int l = 0; l < nl; l++)
      for (int x = 0; x < np; x++)
        if (l < V * BH && x < H * BW) begin
          y = y_of(pix[l][x]);
          if (y > mx[l / BH][x / BW]) mx[l / BH][x / BW] = y;
          sm[l / BH][x / BW] += y;
        end
    for (int zy = 0; zy < V; zy++)
      if (nl >= (zy + 1) * BH)
        for (int zx = 0; zx < H; zx++) begin
          r.h   = zx;
          r.v   = zy;
          r.mx  = mx[zy][zx];
          r.av  = sm[zy][zx] / (BW * BH);
          r.cyc = 0;
          exp_q.push_back(r);
        end
  endtask

  task automatic drive_lines(input int l0, input int l1, input int np);
    for (int l = l0; l < l1; l++) begin
      for (int x = 0; x < np; x++) begin
        iDE = 1'b1;
        iQE = pix[l][x];
        tick();
      end
      iDE = 1'b0;
      iQE = '0;
      repeat (6) tick();
    end
  endtask

  task automatic do_vsync();
    iDE    = 1'b0;
    iVSYNC = 1'b1;
    tick();
    tick();
    iVSYNC = 1'b0;
    tick();
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic compare(input string tag);
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) begin
        chk($sformatf("%s[%0d].h", tag, i), got_q[i].h, exp_q[i].h);
        chk($sformatf("%s[%0d].v", tag, i), got_q[i].v, exp_q[i].v);
        chk($sformatf("%s[%0d].max", tag, i), got_q[i].mx, exp_q[i].mx);
`ifdef INUNIT_BLK_AVG_EN
        chk($sformatf("%s[%0d].avg", tag, i), got_q[i].av, exp_q[i].av);
`endif
      end
  endtask

  task automatic frame_check(input string tag, input int nl, input int np, input int mode);
    int n;
    rdy_mode = mode;
    clear_mon();
    build_exp(nl, np);
    drive_lines(0, nl, np);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
    compare(tag);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    if (got_q.size() > 0)
      chk({tag, ".done_lat"}, done_cyc, got_q[got_q.size() - 1].cyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, oBlk_Valid, 0);
    chk({tag, ".hidx"}, oBlk_HIdx, 0);
    chk({tag, ".vidx"}, oBlk_VIdx, 0);
    chk({tag, ".max"}, oBlk_Max, 0);
    chk({tag, ".avg"}, oBlk_Avg, 0);
    chk({tag, ".done"}, oFrame_Done, 0);
    chk({tag, ".ovf"}, oOvf, 0);
  endtask

  initial begin
    logic [25:0] snap;

    // Reset state
    #12;
    chk_all_zero("reset");
    #1 iRST_n = 1'b1;
    tick();

    // Constant white frame
    do_vsync();
    for (int l = 0; l < 6; l++)
      for (int x = 0; x < 12; x++)
        pix[l][x] = 24'hFFFFFF;
    frame_check("white", 4, 8, 1);

    // Zone 0 ramp 0..7, zone 1 flat 10, second zone row random
    do_vsync();
    fill_random();
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < 8; x++)
        pix[l][x] = (x < 4) ? gray(l * 4 + x) : gray(10);
    frame_check("ramp", 4, 8, 1);

    // Random frames with out-of-range pixels/lines and random ready
    for (int f = 0; f < 3; f++) begin
      do_vsync();
      fill_random();
      frame_check($sformatf("rnd%0d", f), 5, 10, 2);
    end

    // Stall: outputs hold, then two accepts on consecutive cycles
    rdy_mode = 0;
    do_vsync();
    fill_random();
    clear_mon();
    build_exp(2, 8);
    drive_lines(0, 2, 8);
    chk("stall.valid", oBlk_Valid, 1);
    chk("stall.max0", oBlk_Max, exp_q[0].mx);
    snap = {oBlk_Valid, oBlk_HIdx, oBlk_VIdx, oBlk_Max, oBlk_Avg, oOvf};
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall.hold", {oBlk_Valid, oBlk_HIdx, oBlk_VIdx, oBlk_Max, oBlk_Avg, oOvf}, snap);
    end
    chk("stall.no_accept", got_q.size(), 0);
    rdy_mode = 1;
    repeat (4) tick();
    compare("stall");
    if (got_q.size() >= 2)
      chk("stall.b2b", got_q[1].cyc, got_q[0].cyc + 1);
    chk("stall.done_cnt", done_cnt, 0);

    // Overflow: second zone row completes while the first is undrained
    rdy_mode = 0;
    do_vsync();
    fill_random();
    clear_mon();
    build_exp(4, 8);
    while (exp_q.size() > H) void'(exp_q.pop_back());
    drive_lines(0, 4, 8);
    chk("ovf.flag", oOvf, 1);
    chk("ovf.valid", oBlk_Valid, 1);
    chk("ovf.vidx", oBlk_VIdx, 0);
    rdy_mode = 1;
    repeat (10) tick();
    compare("ovf");
    chk("ovf.valid_after", oBlk_Valid, 0);
    chk("ovf.done_cnt", done_cnt, 0);
    chk("ovf.sticky", oOvf, 1);
    do_vsync();
    chk("ovf.cleared", oOvf, 0);

    // VSYNC aborts DRAIN; next frame starts at zone (0,0)
    rdy_mode = 0;
    do_vsync();
    fill_random();
    drive_lines(0, 2, 8);
    chk("vs.valid_pre", oBlk_Valid, 1);
    iVSYNC = 1'b1;
    tick();
    chk("vs.valid_post", oBlk_Valid, 0);
    iVSYNC = 1'b0;
    tick();
    fill_random();
    frame_check("vs_frame", 4, 8, 2);

    // Asynchronous reset mid-line, then a frame with no preceding VSYNC
    rdy_mode = 0;
    do_vsync();
    fill_random();
    drive_lines(0, 4, 8);
    iDE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iQE = 24'($urandom);
      tick();
    end
    #3 iRST_n = 1'b0;
    #1;
    chk_all_zero("arst");
    iDE = 1'b0;
    iQE = '0;
    #3 iRST_n = 1'b1;
    repeat (3) tick();
    fill_random();
    frame_check("post_rst", 5, 10, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inunit_blk_stats.md
Name: inunit_blk_stats

Overview:
- Parametrised successor to the luminance input unit of the dynamic-backlight pipeline.
- Converts the incoming RGB pixel stream to Y and splits the active frame into H_BLOCKS x V_BLOCKS zones.
- Accumulates per-zone max Y (and optionally the mean) and streams one result per zone to the dimming algorithm over a valid/ready handshake.
- Sits between the panel timing inputs (iDE/iVSYNC/iQE) and the ALG unit; replaces fixed 24-pixel packing with per-block statistics.

Parameters:
- H_BLOCKS, 8, zones per row (2..32).
- V_BLOCKS, 8, zones per column (2..32).
- BLK_W, 128, pixels per zone horizontally; power of two.
- BLK_H, 64, lines per zone vertically; power of two.
- Y_W, 8, luminance width; RGB channels are also Y_W bits wide.

Ports:
- iODCK  in  1  pixel clock; all logic on its rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iDE  in  1  data enable; high during active pixels.
- iVSYNC  in  1  frame sync, active high; synchronous frame clear.
- iQE  in  3*Y_W  RGB pixel; R in the top bits, B in the bottom bits.
- oBlk_Valid  out  1  zone result available.
- iBlk_Ready  in  1  consumer accepts when high together with oBlk_Valid.
- oBlk_HIdx  out  clog2(H_BLOCKS)  zone column.
- oBlk_VIdx  out  clog2(V_BLOCKS)  zone row.
- oBlk_Max  out  Y_W  maximum Y in the zone.
- oBlk_Avg  out  Y_W  mean Y in the zone; present only with the optional feature.
- oFrame_Done  out  1  one-cycle pulse after the last zone of the frame is accepted.
- oOvf  out  1  sticky flag: a zone row was dropped.

Behaviour:
- Reset (iRST_n low, asynchronous): all counters, accumulators and state cleared; every output is 0; FSM goes to IDLE.
- Y conversion:
  - Y = (77*R + 150*G + 29*B) >> 8, using an unsigned 18-bit intermediate for Y_W=8.
  - Registered over 3 stages; DE is delayed by 3 cycles in lockstep (DEd).
- Horizontal counter:
  - HC increments on each DEd pixel and clears while DEd is low.
  - Zone column = HC / BLK_W.
  - Pixels with HC >= H_BLOCKS*BLK_W are ignored.
- Vertical counter:
  - VC increments on each falling edge of DEd and clears while iVSYNC is high.
  - Lines with VC >= V_BLOCKS*BLK_H are ignored.
- Accumulation:
  - Per zone column, a running max (Y_W bits) and sum (Y_W + clog2(BLK_W*BLK_H) bits) are kept.
  - Max and sum update on every counted pixel.
  - Both are cleared at the start of each zone row.
- Row complete: the falling edge of DEd on a line where VC % BLK_H == BLK_H-1.
  - On row complete in IDLE: snapshot all columns into the drain buffer, clear the accumulators, then go to DRAIN with column index 0.
  - On row complete while in DRAIN: the new row is dropped, oOvf is set, and the accumulators are still cleared.
- FSM IDLE -> DRAIN -> IDLE:
  - In DRAIN, oBlk_Valid is high and the outputs show buffer[col] with the current zone row index.
  - The outputs hold steady while iBlk_Ready is low.
  - Each accept (valid & ready) advances col.
  - The accept at col == H_BLOCKS-1 returns the FSM to IDLE. On the last zone row it also pulses oFrame_Done on the next cycle.
  - Back-to-back accepts are allowed, giving one zone per cycle.
- iVSYNC high:
  - Clears HC, VC, the accumulators and the zone row index.
  - Aborts DRAIN to IDLE with oBlk_Valid low.
  - Clears oOvf.
  - Has priority over a row complete in the same cycle.
- Max only changes when Y > the current max (strict compare).

Optional Feature:
- Macro INUNIT_BLK_AVG_EN.
- Defined: the sum accumulators and the oBlk_Avg port exist. oBlk_Avg = sum >> clog2(BLK_W*BLK_H) (truncating) and is snapshotted alongside max.
- Undefined: no sum logic and no oBlk_Avg port; max-only behaviour is otherwise identical.

Decomposition:
- Package inunit_pkg holds:
  - the Y coefficients (77, 150, 29, shift 8);
  - the FSM state typedef {IDLE, DRAIN};
  - derived localparam functions for the index, HC/VC and sum widths.
- Sub-module rgb2y_pipe (3-stage Y conversion plus DE delay) is natural and reusable by the older unit.

Test Plan:
- Params H_BLOCKS=2, V_BLOCKS=2, BLK_W=4, BLK_H=2, avg enabled:
  - Feed a frame of constant RGB=(255,255,255) -> Y=255. Expect 4 results, each max=255 and avg=255, order (0,0),(1,0),(0,1),(1,1).
  - oFrame_Done pulses once, 1 cycle after the 4th accept.
- Zone 0 pixels Y ramp 0..7, zone 1 all Y=10 -> row 0 gives zone 0 max=7 avg=3 (28>>3) and zone 1 max=10 avg=10.
- Hold iBlk_Ready low 20 cycles, then high -> outputs are stable while stalled; two accepts in 2 consecutive cycles.
- Keep iBlk_Ready low through two row completions -> oOvf=1. The first row's data is still delivered and the second row is never presented. The next iVSYNC clears oOvf.
- Assert iVSYNC mid-DRAIN -> oBlk_Valid is 0 the next cycle, and the next frame restarts at (0,0).
- Pulse iRST_n low asynchronously mid-line -> all outputs are 0 immediately, and a following full frame reports correct stats.
